// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  localparam int unsigned BURST_W = 4;
  localparam int unsigned WAIT_W  = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: bounded lock hold first, then round-robin.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               cpu_req_i,
  input  logic               dma_req_i,
  input  logic               cpu_lock_i,
  input  logic               dma_lock_i,
  input  logic               last_owner_i,
  input  logic [BURST_W-1:0] burst_cnt_i,
  output logic               grant_valid_o,
  output logic               grant_owner_o
);

  localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

  logic last_req;
  logic last_lock;
  logic keep_last;

  assign last_req  = (last_owner_i == OWNER_DMA) ? dma_req_i  : cpu_req_i;
  assign last_lock = (last_owner_i == OWNER_DMA) ? dma_lock_i : cpu_lock_i;
  // A lock only counts while its owner is actually requesting.
  assign keep_last = last_req && last_lock && (burst_cnt_i < MAX_BURST_C);

  always_comb begin
    grant_valid_o = cpu_req_i | dma_req_i;
    grant_owner_o = last_owner_i;
    if (keep_last) begin
      grant_owner_o = last_owner_i;
    end else if (cpu_req_i && dma_req_i) begin
      grant_owner_o = ~last_owner_i;
    end else if (dma_req_i) begin
      grant_owner_o = OWNER_DMA;
    end else begin
      grant_owner_o = OWNER_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous 8-bit memory port between the CPU and a DMA engine.
//
// state | meaning
// IDLE  | arbitrate; latch winner's access fields
// ISSUE | one-cycle read or write strobe to memory
// WAIT  | count down read latency, capture read data on terminal count
// ACK   | one-cycle acknowledge to the owner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic              owner,
  output logic              busy
);

  localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD   = WAIT_W'(RD_LATENCY - 1);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;

  logic grant_valid;
  logic grant_owner;
  logic last_req;
  logic last_lock;
  logic locked_rpt;
  logic enter_ack;

  mem_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .cpu_req_i     (cpu_req),
    .dma_req_i     (dma_req),
    .cpu_lock_i    (cpu_lock),
    .dma_lock_i    (dma_lock),
    .last_owner_i  (last_q),
    .burst_cnt_i   (burst_q),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

  assign last_req   = (last_q == OWNER_DMA) ? dma_req  : cpu_req;
  assign last_lock  = (last_q == OWNER_DMA) ? dma_lock : cpu_lock;
  // Only a grant won through the lock rule extends the burst.
  assign locked_rpt = (grant_owner == last_q) && last_req && last_lock &&
                      (burst_q < MAX_BURST_C);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    burst_d     = burst_q;
    wait_d      = wait_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    enter_ack   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = ISSUE;
          owner_d = grant_owner;
          last_d  = grant_owner;
          burst_d = locked_rpt ? burst_q + 1'b1 : BURST_W'(1);
          if (grant_owner == OWNER_DMA) begin
            we_d    = dma_we;
            addr_d  = dma_addr;
            wdata_d = dma_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end else begin
          state_d = WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d   = ACK;
          enter_ack = 1'b1;
          if (owner_q == OWNER_DMA) begin
            dma_rdata_d = mem_data_in;
          end else begin
            cpu_rdata_d = mem_data_in;
          end
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enter_ack) begin
      cpu_ack_d = (owner_q == OWNER_CPU);
      dma_ack_d = (owner_q == OWNER_DMA);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWNER_CPU;
      last_q      <= OWNER_DMA;
      burst_q     <= '0;
      wait_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      wait_q      <= wait_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  // Strobes decode straight from the state register so reset kills them at once.
  assign mem_read_en  = (state_q == ISSUE) && !we_q;
  assign mem_write_en = (state_q == ISSUE) && we_q;
  assign mem_addr     = addr_q;
  assign mem_data_out = wdata_q;
  assign cpu_ack      = cpu_ack_q;
  assign dma_ack      = dma_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign dma_rdata    = dma_rdata_q;
  assign owner        = owner_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int RD_LAT = 2;
  localparam int MAX_B  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic        cpu_ack, dma_ack;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in = '0;
  logic        mem_read_en, mem_write_en, owner, busy;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(8), .RD_LATENCY(RD_LAT), .MAX_BURST(MAX_B)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       who;
    logic       we;
    logic [7:0] rdata;
  } ack_exp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } mem_exp_t;

  ack_exp_t   ack_q[$];
  mem_exp_t   mem_q[$];
  logic       ack_log[$];
  int         ack_cyc_log[$];
  int         cyc = 0;
  int         idle_from = 0;
  logic       m_last = 1'b1;
  int         m_burst = 0;
  logic [7:0] m_rdata [2];
  int         pass_cnt = 0;
  int         chk_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h1C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory: data is only correct in the cycle RD_LAT cycles after the read strobe.
  initial begin
    int          rd_cnt;
    logic        rd_act;
    logic [15:0] rd_addr;
    rd_cnt = 0; rd_act = 1'b0; rd_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) rd_act = 1'b0;
      else if (mem_read_en) begin rd_act = 1'b1; rd_cnt = 0; rd_addr = mem_addr; end
      else if (rd_act) rd_cnt++;
      mem_data_in = (rd_act && rd_cnt == RD_LAT) ? mem_fn(rd_addr) : ~mem_fn(rd_addr);
    end
  end

  // Monitor checks what the DUT presents, then the model decides the next grant.
  initial begin
    ack_exp_t    e;
    mem_exp_t    m;
    logic        lreq, llock, locked, win;
    int          oth;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      chk("busy", busy, 32'(cyc < idle_from));

      if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
        e = ack_q.pop_front();
        oth = e.who ? 0 : 1;
        chk("cpu_ack", cpu_ack, 32'(e.who == 1'b0));
        chk("dma_ack", dma_ack, 32'(e.who == 1'b1));
        chk("owner_at_ack", owner, e.who);
        if (!e.we) begin
          chk(e.who ? "dma_rdata" : "cpu_rdata", e.who ? dma_rdata : cpu_rdata, e.rdata);
          m_rdata[e.who ? 1 : 0] = e.rdata;
        end
        chk("rdata_hold", oth == 1 ? dma_rdata : cpu_rdata, m_rdata[oth]);
        ack_log.push_back(e.who);
        ack_cyc_log.push_back(cyc);
      end else begin
        chk("no_ack", {cpu_ack, dma_ack}, 0);
      end

      if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
        m = mem_q.pop_front();
        chk("mem_write_en", mem_write_en, m.we);
        chk("mem_read_en", mem_read_en, !m.we);
        chk("mem_addr", mem_addr, m.addr);
        if (m.we) chk("mem_data_out", mem_data_out, m.wdata);
      end else begin
        chk("no_strobe", {mem_read_en, mem_write_en}, 0);
      end

      if (cyc >= idle_from && (cpu_req || dma_req)) begin
        lreq   = m_last ? dma_req  : cpu_req;
        llock  = m_last ? dma_lock : cpu_lock;
        locked = lreq && llock && (m_burst < MAX_B);
        if (locked) win = m_last;
        else if (cpu_req && dma_req) win = !m_last;
        else win = dma_req;
        m_burst = locked ? m_burst + 1 : 1;
        m_last  = win;
        m.cyc   = cyc + 1;
        m.we    = win ? dma_we : cpu_we;
        m.addr  = win ? dma_addr : cpu_addr;
        m.wdata = win ? dma_wdata : cpu_wdata;
        mem_q.push_back(m);
        e.cyc   = m.we ? cyc + 2 : cyc + 2 + RD_LAT;
        e.who   = win;
        e.we    = m.we;
        e.rdata = mem_fn(m.addr);
        ack_q.push_back(e);
        idle_from = e.cyc + 1;
      end
    end
  end

  task automatic txn(input bit who, input logic we, input logic [15:0] addr,
                     input logic [7:0] wd, input logic lk);
    int n;
    if (who) begin dma_we = we; dma_addr = addr; dma_wdata = wd; dma_lock = lk; dma_req = 1'b1; end
    else     begin cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_lock = lk; cpu_req = 1'b1; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(who ? dma_ack : cpu_ack) && n < 100);
    if (n >= 100) chk(who ? "dma_ack_timeout" : "cpu_ack_timeout", who ? dma_ack : cpu_ack, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle_req(input bit who, input int cycles);
    if (who) begin dma_req = 1'b0; dma_lock = 1'b0; end
    else     begin cpu_req = 1'b0; cpu_lock = 1'b0; end
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic stream(input bit who, input int n, input int lock_pct,
                        input bit gaps, input bit reads);
    for (int i = 0; i < n; i++) begin
      txn(who, reads ? 1'($urandom_range(0, 1)) : 1'b1, 16'($urandom), 8'($urandom),
          1'($urandom_range(0, 99) < lock_pct));
      if (gaps && $urandom_range(0, 2) == 0) idle_req(who, $urandom_range(1, 3));
    end
    idle_req(who, 0);
  endtask

  initial begin
    int   n;
    logic burst_pat [10];
    burst_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    m_rdata[0] = '0;
    m_rdata[1] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_rd_en", mem_read_en, 0);
    chk("rst_wr_en", mem_write_en, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data_out", mem_data_out, 0);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    ack_log.delete(); ack_cyc_log.delete();
    fork
      begin txn(0, 1'b1, 16'h1234, 8'hA5, 1'b0); idle_req(0, 0); end
      begin txn(1, 1'b1, 16'h0BEE, 8'h11, 1'b0); idle_req(1, 0); end
    join
    chk("first_grant_cpu", ack_log[0], 0);
    chk("second_grant_dma", ack_log[1], 1);
    chk("write_spacing", ack_cyc_log[1] - ack_cyc_log[0], 3);

    txn(1, 1'b0, 16'h0040, 8'h00, 1'b0);
    idle_req(1, 0);
    chk("dma_read_5c_held", dma_rdata, 8'h5C);

    ack_log.delete(); ack_cyc_log.delete();
    fork
      stream(0, 4, 0, 1'b0, 1'b0);
      stream(1, 4, 0, 1'b0, 1'b0);
    join
    for (int i = 0; i < 4; i++) chk("rr_order", ack_log[i], i % 2);
    for (int i = 0; i < 3; i++) chk("rr_spacing", ack_cyc_log[i + 1] - ack_cyc_log[i], 3);

    txn(0, 1'b1, 16'h2000, 8'h3C, 1'b0);
    idle_req(0, 0);
    ack_log.delete(); ack_cyc_log.delete();
    fork
      stream(1, 10, 100, 1'b0, 1'b0);
      stream(0, 4, 0, 1'b0, 1'b0);
    join
    for (int i = 0; i < 10; i++) chk("burst_order", ack_log[i], burst_pat[i]);

    fork
      stream(0, 30, 30, 1'b1, 1'b1);
      stream(1, 30, 30, 1'b1, 1'b1);
    join
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", ack_q.size() + mem_q.size(), 0);

    dma_we = 1'b0; dma_addr = 16'h0040; dma_lock = 1'b0; dma_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_read_en && n < 20);
    chk("rd_strobe_seen", mem_read_en, 1);
    @(posedge clk); #2;
    chk("busy_in_wait", busy, 1);
    rst_n = 1'b0;
    ack_q.delete(); mem_q.delete();
    m_last = 1'b1; m_burst = 0; idle_from = 0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    #1;
    chk("rst_mid_strobes", {mem_read_en, mem_write_en}, 0);
    chk("rst_mid_acks", {cpu_ack, dma_ack}, 0);
    chk("rst_mid_busy", busy, 0);
    dma_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    n = 0;
    repeat (10) begin @(negedge clk); if (cpu_ack || dma_ack) n++; end
    chk("ack_after_reset", n, 0);
    chk("busy_after_reset", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the CPU's single 8-bit memory port between the CPU core and a DMA/loader engine. It sits between the CPU's `mem_*` bus, a second requester, and the external synchronous memory. It serialises accesses through a small FSM, applies round-robin fairness with an optional bounded burst lock, and returns read data with a registered acknowledge.

## Interface
- `ADDR_W`, 16, address width.
- `DATA_W`, 8, data width.
- `RD_LATENCY`, 1, memory read latency in cycles (legal 1..4).
- `MAX_BURST`, 4, maximum consecutive locked grants to one owner (legal 1..15).

Ports. Clock is `clk`; reset is `rst_n`, asynchronous, active-low. Requester prefix `x_` is `cpu_` or `dma_`.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `x_req` in 1: access request; held high, with fields stable, until `x_ack`.
- `x_we` in 1: 1 = write, 0 = read.
- `x_addr` in ADDR_W: access address.
- `x_wdata` in DATA_W: write data.
- `x_lock` in 1: request to keep the grant for following accesses.
- `x_ack` out 1: one-cycle completion pulse.
- `x_rdata` out DATA_W: read data, valid while `x_ack` is high; held afterwards.
- `mem_addr` out ADDR_W: memory address.
- `mem_data_out` out DATA_W: memory write data.
- `mem_data_in` in DATA_W: memory read data.
- `mem_read_en` out 1: memory read strobe.
- `mem_write_en` out 1: memory write strobe.
- `owner` out 1: current or last owner (0 = CPU, 1 = DMA).
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT, ACK.
- **IDLE arbitration** (one grant per IDLE cycle with any request):
  - If the last owner has `req` and `lock` high and `burst_cnt < MAX_BURST`, the last owner wins.
  - Otherwise, round-robin: the requester that is not the last owner wins when both request.
  - The winner's `we`, `addr` and `wdata` are latched.
  - `burst_cnt` increments on a locked repeat grant and resets to 1 on any other grant.
- **ISSUE** (exactly one cycle):
  - Drives latched `mem_addr` and `mem_data_out`.
  - Asserts `mem_write_en` (write) or `mem_read_en` (read).
  - Write → ACK. Read → WAIT.
- **WAIT:**
  - Counts `RD_LATENCY` cycles.
  - `mem_data_in` is sampled at the end of the last WAIT cycle into the owner's `rdata` register.
  - Then → ACK.
- **ACK:**
  - The owner's `ack` is high for one cycle; the other requester's `ack` stays 0.
  - Then → IDLE. There is no back-to-back ISSUE; a requester presents its next access after seeing `ack`.
- **Hold behaviour:** `mem_addr` and `mem_data_out` hold their latched values outside ISSUE. Strobes are high only in ISSUE.
- **`req` dropped mid-transaction:** this is a protocol violation. The transaction still completes and `ack` still pulses.
- **`lock` without `req`:** ignored; the grant follows round-robin.

## Timing
- Reset value of all outputs is 0, including `owner`. The round-robin pointer (last owner) resets to DMA, so the CPU wins the first contested grant. `burst_cnt` resets to 0.
- Count cycle 0 as the IDLE cycle in which the request is sampled.
  - Write: ISSUE in cycle 1, `ack` in cycle 2.
  - Read: ISSUE in cycle 1, WAIT in cycles 2..1+RD_LATENCY, `ack` in cycle 2+RD_LATENCY.
- Minimum transaction period: 3 cycles for a write, 3+RD_LATENCY cycles for a read.
- `rst_n` asserted in any state:
  - Immediately forces IDLE and drops `mem_read_en`, `mem_write_en` and both `ack` outputs.
  - No `ack` is issued for the aborted access after reset is released.
- Widths: `burst_cnt` is 4 bits and saturates at `MAX_BURST`. The WAIT counter is 3 bits.

## Structure
- A shared package `mem_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, ACK);
  - owner constants `OWNER_CPU = 1'b0` and `OWNER_DMA = 1'b1`.
- One combinational sub-module, `mem_arb_pick`, computes the winner.
  - Inputs: both `req`, both `lock`, last owner, `burst_cnt`.
  - Outputs: `grant_valid`, `grant_owner`.
- The FSM, latches and counters live in the top module.

## Test plan
- **Reset:** hold `rst_n` = 0 → all outputs 0. Release and raise `cpu_req` and `dma_req` together → the CPU is granted first (`owner` = 0).
- **CPU write:** `cpu_we` = 1, `cpu_addr` = 0x1234, `cpu_wdata` = 0xA5 → `mem_write_en` = 1 in cycle 1 with `mem_addr` = 0x1234 and `mem_data_out` = 0xA5. `cpu_ack` = 1 in cycle 2 only. `dma_ack` stays 0.
- **DMA read, `RD_LATENCY` = 2:** `dma_addr` = 0x0040, memory returns 0x5C → `mem_read_en` in cycle 1. `dma_ack` in cycle 4 with `dma_rdata` = 0x5C.
- **Contention without lock:** both requesters issue continuous writes → grants alternate CPU, DMA, CPU, DMA, with a 3-cycle spacing between acks.
- **Burst lock, `MAX_BURST` = 4:** `dma_lock` = 1 with `dma_req` and `cpu_req` both continuously high → 4 consecutive DMA acks, then one CPU grant, then DMA again.
- **Reset mid-read, `RD_LATENCY` = 3:** pull `rst_n` low during WAIT → strobes are 0 in the same cycle. No `ack` after release; `busy` = 0.
